// File: rtl/uart_status_tx_if.sv
// Write port toward simpleuart: strobe and data from the reporter, stall back from the UART.
interface uart_status_tx_if;
    logic        reg_dat_we;
    logic [31:0] reg_dat_di;
    logic        reg_dat_wait;

    modport master (
        output reg_dat_we,
        output reg_dat_di,
        input  reg_dat_wait
    );

    modport slave (
        input  reg_dat_we,
        input  reg_dat_di,
        output reg_dat_wait
    );
endinterface

// File: rtl/uart_status_tx.sv
// Sends 4-byte ASCII status messages (cause, digit, CR, LF) describing the RGB LED state
// on request, on state change, or on heartbeat expiry.
module uart_status_tx #(
    parameter int unsigned HEARTBEAT_CYCLES = 32'd12000000
) (
    input  logic             hw_clk,
    input  logic             resetn,
    input  logic [2:0]       rgb_state,
    input  logic             send_req,
    uart_status_tx_if.master uart,
    output logic             busy,
    output logic [15:0]      msg_count
);
    typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

    localparam logic [7:0] CauseReq    = 8'h52;
    localparam logic [7:0] CauseChange = 8'h43;
    localparam logic [7:0] CauseBeat   = 8'h48;
    localparam bit          HbEnable   = (HEARTBEAT_CYCLES != 0);
    localparam logic [31:0] HbLast     = HbEnable ? 32'(HEARTBEAT_CYCLES - 1) : 32'd0;

    state_e      state_q;
    logic [1:0]  idx_q;
    logic [7:0]  cause_q;
    logic [2:0]  snap_q;
    logic [2:0]  last_sent_q;
    logic        pend_r_q;
    logic        pend_h_q;
    logic [31:0] hb_cnt_q;
    logic        pend_c;
    logic        hb_fire;

    assign pend_c = (rgb_state != last_sent_q);
    // Expiry coinciding with DONE is dropped: the counter clear takes precedence.
    assign hb_fire = HbEnable && (hb_cnt_q == HbLast) && (state_q != StDone);

    function automatic logic [7:0] msg_byte(input logic [1:0] idx, input logic [7:0] cause,
                                            input logic [2:0] snap);
        case (idx)
            2'd0:    msg_byte = cause;
            2'd1:    msg_byte = 8'h30 + {5'd0, snap};
            2'd2:    msg_byte = 8'h0D;
            default: msg_byte = 8'h0A;
        endcase
    endfunction

    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= StIdle;
            idx_q           <= 2'd0;
            cause_q         <= 8'd0;
            snap_q          <= 3'd0;
            last_sent_q     <= 3'd0;
            pend_r_q        <= 1'b0;
            pend_h_q        <= 1'b0;
            hb_cnt_q        <= 32'd0;
            busy            <= 1'b0;
            msg_count       <= 16'd0;
            uart.reg_dat_we <= 1'b0;
            uart.reg_dat_di <= 32'd0;
        end else begin
            if (state_q == StDone || hb_fire) begin
                hb_cnt_q <= 32'd0;
            end else if (HbEnable) begin
                hb_cnt_q <= hb_cnt_q + 32'd1;
            end
            if (hb_fire) begin
                pend_h_q <= 1'b1;
            end
            if (send_req) begin
                pend_r_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (pend_r_q || pend_c || pend_h_q) begin
                        state_q         <= StSend;
                        idx_q           <= 2'd0;
                        snap_q          <= rgb_state;
                        busy            <= 1'b1;
                        uart.reg_dat_we <= 1'b1;
                        // A request arriving in this very cycle stays pending.
                        if (pend_r_q) begin
                            cause_q         <= CauseReq;
                            uart.reg_dat_di <= {24'd0, CauseReq};
                            pend_r_q        <= send_req;
                        end else if (pend_c) begin
                            cause_q         <= CauseChange;
                            uart.reg_dat_di <= {24'd0, CauseChange};
                        end else begin
                            cause_q         <= CauseBeat;
                            uart.reg_dat_di <= {24'd0, CauseBeat};
                            pend_h_q        <= hb_fire;
                        end
                    end
                end
                StSend: begin
                    if (!uart.reg_dat_wait) begin
                        if (idx_q == 2'd3) begin
                            state_q         <= StDone;
                            uart.reg_dat_we <= 1'b0;
                            uart.reg_dat_di <= 32'd0;
                        end else begin
                            idx_q           <= idx_q + 2'd1;
                            uart.reg_dat_di <= {24'd0, msg_byte(idx_q + 2'd1, cause_q, snap_q)};
                        end
                    end
                end
                StDone: begin
                    state_q     <= StIdle;
                    busy        <= 1'b0;
                    msg_count   <= msg_count + 16'd1;
                    last_sent_q <= snap_q;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_status_tx.sv
// Directed bench for uart_status_tx: expected bytes are queued as stimulus is driven and
// popped as each accepted write is observed.
module tb_uart_status_tx;
    logic        hw_clk = 1'b0;
    logic        resetn;
    logic        resetn_hb;
    logic [2:0]  rgb_state;
    logic        send_req;
    logic        wait0;
    logic        busy0;
    logic        busy1;
    logic [15:0] cnt0;
    logic [15:0] cnt1;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          we_cyc0 = 0;
    logic [7:0]  exp_q0[$];
    logic [7:0]  exp_q1[$];
    int          h_times[$];
    logic [31:0] exp_w0;
    logic [31:0] exp_w1;

    always #5 hw_clk = ~hw_clk;
    always @(posedge hw_clk) cyc++;

    uart_status_tx_if bus0();
    uart_status_tx_if bus1();
    assign bus0.reg_dat_wait = wait0;
    assign bus1.reg_dat_wait = 1'b0;

    uart_status_tx #(.HEARTBEAT_CYCLES(0)) dut (
        .hw_clk    (hw_clk),
        .resetn    (resetn),
        .rgb_state (rgb_state),
        .send_req  (send_req),
        .uart      (bus0),
        .busy      (busy0),
        .msg_count (cnt0)
    );

    uart_status_tx #(.HEARTBEAT_CYCLES(100)) dut_hb (
        .hw_clk    (hw_clk),
        .resetn    (resetn_hb),
        .rgb_state (3'd0),
        .send_req  (1'b0),
        .uart      (bus1),
        .busy      (busy1),
        .msg_count (cnt1)
    );

    // Scoreboard: a write is accepted at the coming edge when we=1 and wait=0.
    always @(negedge hw_clk) begin
        if (bus0.reg_dat_we) we_cyc0++;
        if (bus0.reg_dat_we && !wait0) begin
            checks++;
            exp_w0 = (exp_q0.size() == 0) ? 32'hDEAD_BEEF : {24'd0, exp_q0.pop_front()};
            assert (bus0.reg_dat_di === exp_w0) else begin
                failures++;
                $error("FAIL write0 observed=%h expected=%h", bus0.reg_dat_di, exp_w0);
            end
        end
        if (bus1.reg_dat_we) begin
            checks++;
            exp_w1 = (exp_q1.size() == 0) ? 32'hDEAD_BEEF : {24'd0, exp_q1.pop_front()};
            assert (bus1.reg_dat_di === exp_w1) else begin
                failures++;
                $error("FAIL write_hb observed=%h expected=%h", bus1.reg_dat_di, exp_w1);
            end
            if (bus1.reg_dat_di == 32'h48) h_times.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge hw_clk);
        #1;
    endtask

    task automatic push0(input logic [7:0] cause, input logic [2:0] digit);
        exp_q0.push_back(cause);
        exp_q0.push_back(8'h30 + {5'd0, digit});
        exp_q0.push_back(8'h0D);
        exp_q0.push_back(8'h0A);
    endtask

    task automatic wait_cnt0(input logic [15:0] target, input int budget);
        int n = 0;
        while (cnt0 !== target && n < budget) begin
            step(1);
            n++;
        end
        check("wait_msg_count", {16'd0, cnt0}, {16'd0, target});
    endtask

    task automatic pulse_req();
        send_req = 1'b1;
        step(1);
        send_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn    = 1'b0;
        resetn_hb = 1'b0;
        rgb_state = 3'd0;
        send_req  = 1'b0;
        wait0     = 1'b0;
        step(3);
        check("rst_we", {31'd0, bus0.reg_dat_we}, 32'd0);
        check("rst_di", bus0.reg_dat_di, 32'd0);
        check("rst_busy", {31'd0, busy0}, 32'd0);
        check("rst_count", {16'd0, cnt0}, 32'd0);

        // Quiet idle: any write here is unexpected.
        resetn = 1'b1;
        step(1000);
        check("idle_we", {31'd0, bus0.reg_dat_we}, 32'd0);
        check("idle_busy", {31'd0, busy0}, 32'd0);
        check("idle_count", {16'd0, cnt0}, 32'd0);

        // Change 0 -> 3.
        we_cyc0 = 0;
        push0(8'h43, 3'd3);
        rgb_state = 3'd3;
        step(1);
        check("chg_latency_we", {31'd0, bus0.reg_dat_we}, 32'd1);
        check("chg_busy", {31'd0, busy0}, 32'd1);
        wait_cnt0(16'd1, 50);
        check("chg_busy_after", {31'd0, busy0}, 32'd0);
        check("chg_we_cycles", we_cyc0, 32'd4);
        check("chg_queue", exp_q0.size(), 32'd0);

        push0(8'h43, 3'd0);
        rgb_state = 3'd0;
        wait_cnt0(16'd2, 50);

        // Request with a 20-cycle stall on byte1.
        we_cyc0 = 0;
        push0(8'h52, 3'd0);
        pulse_req();
        step(1);
        check("req_latency_we", {31'd0, bus0.reg_dat_we}, 32'd1);
        check("req_byte0", bus0.reg_dat_di, 32'h52);
        step(1);
        wait0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("stall_di", bus0.reg_dat_di, 32'h30);
            check("stall_we", {31'd0, bus0.reg_dat_we}, 32'd1);
            step(1);
        end
        wait0 = 1'b0;
        wait_cnt0(16'd3, 50);
        check("stall_we_cycles", we_cyc0, 32'd24);
        check("stall_queue", exp_q0.size(), 32'd0);

        // Requests coalesce; the state change rides on the next R message.
        push0(8'h52, 3'd0);
        push0(8'h52, 3'd5);
        pulse_req();
        step(2);
        pulse_req();
        send_req  = 1'b1;
        rgb_state = 3'd5;
        step(1);
        send_req = 1'b0;
        wait_cnt0(16'd5, 60);
        step(50);
        check("coalesce_count", {16'd0, cnt0}, 32'd5);
        check("coalesce_queue", exp_q0.size(), 32'd0);
        check("coalesce_busy", {31'd0, busy0}, 32'd0);

        // Reset while byte2 is presented.
        exp_q0.push_back(8'h52);
        exp_q0.push_back(8'h35);
        pulse_req();
        step(3);
        check("pre_rst_byte2", bus0.reg_dat_di, 32'h0D);
        resetn = 1'b0;
        #1;
        check("async_rst_we", {31'd0, bus0.reg_dat_we}, 32'd0);
        check("async_rst_di", bus0.reg_dat_di, 32'd0);
        check("async_rst_count", {16'd0, cnt0}, 32'd0);
        rgb_state = 3'd0;
        step(2);
        resetn = 1'b1;
        step(100);
        check("post_rst_we", {31'd0, bus0.reg_dat_we}, 32'd0);
        check("post_rst_count", {16'd0, cnt0}, 32'd0);
        check("post_rst_queue", exp_q0.size(), 32'd0);

        // Heartbeat: three H0 messages, evenly spaced.
        for (int m = 0; m < 3; m++) begin
            exp_q1.push_back(8'h48);
            exp_q1.push_back(8'h30);
            exp_q1.push_back(8'h0D);
            exp_q1.push_back(8'h0A);
        end
        resetn_hb = 1'b1;
        for (int n = 0; n < 600 && cnt1 !== 16'd3; n++) step(1);
        check("hb_count", {16'd0, cnt1}, 32'd3);
        resetn_hb = 1'b0;
        check("hb_queue", exp_q1.size(), 32'd0);
        check("hb_times", h_times.size(), 32'd3);
        if (h_times.size() == 3) begin
            check("hb_period1", h_times[1] - h_times[0], 32'd106);
            check("hb_period2", h_times[2] - h_times[1], 32'd106);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_status_tx.md
# uart_status_tx

Status reporter that sends ASCII status messages from the board to the host over the `simpleuart` write port. It is the transmit-side counterpart to the LED command decoder. It watches the 3-bit RGB LED state and formats a 4-byte message whenever one of three things happens: the state changes, an explicit request arrives, or a heartbeat period expires. It sits between the LED control logic and `simpleuart`, and drives `reg_dat_we`/`reg_dat_di` while honouring `reg_dat_wait`.

## Interface
- `HEARTBEAT_CYCLES`, default 12000000: heartbeat period in `hw_clk` cycles (1 s at 12 MHz). 0 disables the heartbeat.
- `hw_clk`  in  1  system clock, 12 MHz hardware oscillator.
- `resetn`  in  1  asynchronous, active-low reset.
- `rgb_state`  in  3  current LED state, bit0 = red, bit1 = green, bit2 = blue. Synchronous to `hw_clk`.
- `send_req`  in  1  single-cycle request to report the state now.
- `reg_dat_wait`  in  1  `simpleuart` busy/stall for the current write.
- `reg_dat_we`  out  1  write strobe to `simpleuart`.
- `reg_dat_di`  out  32  write data; bits [31:8] are always 0.
- `busy`  out  1  high while a message is in flight.
- `msg_count`  out  16  number of completed messages; wraps modulo 2^16.

## Operation
- **Message format** (4 bytes, in order): cause, digit, `"\r"` (0x0D), `"\n"` (0x0A).
  - Cause byte: `"R"` (0x52) for a request, `"C"` (0x43) for a change, `"H"` (0x48) for a heartbeat.
  - Digit byte: `"0"` + snapshot, i.e. 0x30 + {blue,green,red}, range 0x30–0x37.
- **Triggers:**
  - `pend_r`: set by `send_req`, sticky until serviced.
  - `pend_c`: combinational, equals `rgb_state != last_sent`. It is not latched, so a change that reverts before service sends nothing.
  - `pend_h`: set when the heartbeat counter reaches `HEARTBEAT_CYCLES-1`. The counter then returns to 0. Sticky until serviced.
- **Arbitration:** when several triggers are pending, priority is R > C > H. Only the chosen cause's pending bit is cleared. Any remaining pending causes are serviced by following messages. `pend_c` clears itself once `last_sent` matches.
- **States:**
  - IDLE: `reg_dat_we`=0, `busy`=0. If any trigger is pending, latch cause, latch `snap`=`rgb_state`, clear the chosen pending bit, go to SEND with index 0.
  - SEND: `reg_dat_we`=1, `reg_dat_di`=byte[index], `busy`=1.
    - A byte is accepted on a rising edge where `reg_dat_we`=1 and `reg_dat_wait`=0.
    - On acceptance with index<3: index+1, and the next byte is presented the following cycle. `we` stays high.
    - On acceptance with index=3: go to DONE.
    - While `reg_dat_wait`=1: hold `reg_dat_di` and `we` unchanged. There is no timeout.
  - DONE (1 cycle): `reg_dat_we`=0, `busy`=1. Then `msg_count`+1, `last_sent`=`snap`, heartbeat counter cleared to 0, go to IDLE.
- **Input changes during a message:**
  - `rgb_state` changing mid-message does not alter the bytes already latched. It raises `pend_c` for the next message.
  - `send_req` arriving during a message sets `pend_r`. Multiple requests coalesce into one.
- **Heartbeat:** the counter (32-bit) runs in every state and is cleared in DONE. A heartbeat therefore fires only after `HEARTBEAT_CYCLES` cycles with no completed message.

## Timing
- **Reset values:**
  - Outputs: `reg_dat_we`=0, `reg_dat_di`=0, `busy`=0, `msg_count`=0.
  - Internal: `last_sent`=0, all pending bits 0, heartbeat counter 0, state IDLE.
- **Latency:**
  - `send_req` sampled high at edge k: IDLE sees `pend_r` at edge k+1, and `we`=1 with byte0 from cycle k+2.
  - A `rgb_state` change at edge k gives `we`=1 from cycle k+1.
- **Minimum message length:** 4 SEND cycles + 1 DONE cycle when `reg_dat_wait`=0 throughout. The earliest next-message `we` comes 1 cycle after DONE (IDLE re-evaluation), so back-to-back messages always have at least 2 cycles with `we`=0 between them.
- **Simultaneous events:**
  - `send_req` together with a `rgb_state` change gives an "R" message carrying the new state. `pend_c` then clears because `last_sent` matches, so no extra "C".
  - A heartbeat expiry in the same cycle as DONE is dropped, because the counter clear wins.
- **Reset mid-message:** `we` drops immediately (asynchronously). The partial message is abandoned and never resent.
- **Counter wrap:** `msg_count` 0xFFFF + 1 → 0x0000.

## Test plan
- Reset with `rgb_state`=0, `HEARTBEAT_CYCLES`=0, `wait`=0 → no writes for 1000 cycles; all outputs 0.
- `rgb_state` 0→3 → bytes 0x43, 0x33, 0x0D, 0x0A on 4 consecutive cycles; then `msg_count`=1 and `busy`=0.
- `send_req` pulse with `reg_dat_wait` held high 20 cycles on byte1 → byte1 (0x30) stays stable across the stall; the full message is "R0\r\n" and `msg_count` increments once.
- During an "R" message, `send_req` is pulsed twice and `rgb_state` goes 0→5 → the next message is "R5\r\n" and no "C" message follows.
- `HEARTBEAT_CYCLES`=100, idle → "H0\r\n" issued every 100 + message-length cycles.
- Assert `resetn` low during byte2, then release → `we` is 0 immediately; no bytes after release; `msg_count`=0.
